// File: rtl/uart_tx_param_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : uart_tx_param_pkg                                            |
// | Description : Shared definitions for the parametrised UART transmitter:    |
// |               FSM state encoding, parity-mode constants and a clog2 helper |
// |               usable in constant expressions.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uart_tx_param_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int c_PARITY_NONE = 0;
  localparam int c_PARITY_EVEN = 1;
  localparam int c_PARITY_ODD  = 2;

  // Smallest r with 2**r >= value (value >= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_param_baud_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_baud_tick                                               |
// | Description : Baud counter. Emits a 1-clk tick in the last clk of every    |
// |               CLKS_PER_BIT-clk bit period. restart synchronously holds the |
// |               count at zero so the next period starts cleanly.             |
// | Ports       : clk, rst (async, active high), restart (sync), tick          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_baud_tick
  import uart_tx_param_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int c_CW = clog2(CLKS_PER_BIT);
  localparam logic [c_CW-1:0] c_MAX = c_CW'(CLKS_PER_BIT - 1);

  logic [c_CW-1:0] r_cnt;

  assign tick = (r_cnt == c_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (restart || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_param                                                |
// | Description : Parametrised UART transmitter (start, DATA_BITS LSB first,   |
// |               optional parity, STOP_BITS stop bits) with valid/ready input |
// |               handshake allowing gap-free back-to-back frames.             |
// | Macro       : UART_TX_PARITY_EN - enables the parity bit (PARITY_MODE)     |
// | Ports       : clk, rst (async, active high), en (low aborts to idle)       |
// |               txValid/txIn/txReady - producer handshake                    |
// |               busy - frame in progress, done - last clk of final stop bit  |
// |               txOut - serial line, idle high                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_param
  import uart_tx_param_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 txValid,
  input  logic [DATA_BITS-1:0] txIn,
  output logic                 txReady,
  output logic                 busy,
  output logic                 done,
  output logic                 txOut
);

  localparam int c_BW = clog2(DATA_BITS);
  localparam logic [c_BW-1:0] c_LAST_DATA = c_BW'(DATA_BITS - 1);
  localparam logic [c_BW-1:0] c_LAST_STOP = c_BW'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  localparam bit c_HAS_PARITY = (PARITY_MODE != c_PARITY_NONE);
`else
  // PARITY_MODE is deliberately ignored in this build.
  localparam bit c_HAS_PARITY = 1'b0 & (PARITY_MODE != c_PARITY_NONE);
`endif

  tx_state_t            r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_shreg, w_shreg_nxt;
  logic [c_BW-1:0]      r_bitcnt, w_bitcnt_nxt;
  logic                 w_tick;
  logic                 w_restart;
  logic                 w_last_stop;
  logic                 w_accept;
  logic                 w_par_bit;
  logic                 w_tx;

  // Counter is held at zero while idle or disabled; all other state changes
  // happen on a tick, where the counter wraps to zero by itself.
  assign w_restart = (r_state == ST_IDLE) || !en;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (w_restart),
    .tick    (w_tick)
  );

  assign w_last_stop = (r_state == ST_STOP) && w_tick && (r_bitcnt == c_LAST_STOP);
  // rst gating keeps txReady low for the whole reset window even with en high.
  assign txReady     = en && !rst && ((r_state == ST_IDLE) || w_last_stop);
  assign done        = en && w_last_stop;
  assign busy        = (r_state != ST_IDLE);
  assign w_accept    = txValid && txReady;
  assign txOut       = w_tx;

`ifdef UART_TX_PARITY_EN
  logic r_par;

  // Parity is computed from the word as it is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= (PARITY_MODE == c_PARITY_EVEN) ? ^txIn : ~^txIn;
    end
  end

  assign w_par_bit = r_par;
`else
  assign w_par_bit = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_bitcnt <= w_bitcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_bitcnt_nxt = r_bitcnt;
    w_tx         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_START;
          w_shreg_nxt = txIn;
        end
      end
      ST_START: begin
        w_tx = 1'b0;
        if (w_tick) begin
          w_state_nxt  = ST_DATA;
          w_bitcnt_nxt = '0;
        end
      end
      ST_DATA: begin
        w_tx = r_shreg[0];
        if (w_tick) begin
          w_shreg_nxt = {1'b0, r_shreg[DATA_BITS-1:1]};
          if (r_bitcnt == c_LAST_DATA) begin
            w_bitcnt_nxt = '0;
            w_state_nxt  = c_HAS_PARITY ? ST_PARITY : ST_STOP;
          end else begin
            w_bitcnt_nxt = r_bitcnt + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        w_tx = w_par_bit;
        if (w_tick) begin
          w_state_nxt  = ST_STOP;
          w_bitcnt_nxt = '0;
        end
      end
      ST_STOP: begin
        // Bit counter is reused to count stop bits.
        if (w_tick) begin
          if (r_bitcnt == c_LAST_STOP) begin
            w_bitcnt_nxt = '0;
            if (w_accept) begin
              w_state_nxt = ST_START;
              w_shreg_nxt = txIn;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_bitcnt_nxt = r_bitcnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // Disable aborts any frame; no word can be accepted in this cycle.
    if (!en) begin
      w_state_nxt  = ST_IDLE;
      w_shreg_nxt  = '0;
      w_bitcnt_nxt = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_param                                             |
// | Description : Self-checking bench for uart_tx_param. Two instances:       |
// |               A = 8 data, 1 stop, even parity mode; B = 5 data, 2 stop,    |
// |               odd parity mode; both 4 clks per bit.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_tx_param;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       en_a, valid_a, ready_a, busy_a, done_a, tx_a;
  logic [7:0] in_a;
  logic       en_b, valid_b, ready_b, busy_b, done_b, tx_b;
  logic [4:0] in_b;

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_MODE(1)) u_dut_a (
    .clk(clk), .rst(rst), .en(en_a), .txValid(valid_a), .txIn(in_a),
    .txReady(ready_a), .busy(busy_a), .done(done_a), .txOut(tx_a));

  uart_tx_param #(.DATA_BITS(5), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_MODE(2)) u_dut_b (
    .clk(clk), .rst(rst), .en(en_b), .txValid(valid_b), .txIn(in_b),
    .txReady(ready_b), .busy(busy_b), .done(done_b), .txOut(tx_b));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (frame rules) ----------------
  function automatic int db(input int s);  return (s != 0) ? 5 : 8; endfunction
  function automatic int sb(input int s);  return (s != 0) ? 2 : 1; endfunction
  function automatic int pm(input int s);  return (s != 0) ? 2 : 1; endfunction

  function automatic int frame_len(input int s);
    return 1 + db(s) + (PAR_ON ? 1 : 0) + sb(s);
  endfunction

  // Bit i of the result is the i-th serial bit on the line.
  function automatic logic [15:0] model_frame(input int s, input logic [8:0] d);
    logic [15:0] f;
    logic        p;
    f    = '1;
    p    = 1'b0;
    f[0] = 1'b0;
    for (int k = 0; k < db(s); k++) begin
      f[1+k] = d[k];
      p      = p ^ d[k];
    end
    if (PAR_ON) f[1+db(s)] = (pm(s) == 2) ? ~p : p;
    return f;
  endfunction

  // ---------------- DUT access helpers ----------------
  function automatic logic [3:0] outs(input int s);
    return (s != 0) ? {tx_b, busy_b, done_b, ready_b} : {tx_a, busy_a, done_a, ready_a};
  endfunction

  task automatic set_in(input int s, input logic v, input logic [8:0] d);
    if (s != 0) begin valid_b = v; in_b = d[4:0]; end
    else        begin valid_a = v; in_a = d[7:0]; end
  endtask

  task automatic set_en(input int s, input logic e);
    if (s != 0) en_b = e; else en_a = e;
  endtask

  task automatic check_cycle(input string name, input int s,
                             input logic tx, input logic bz, input logic dn, input logic rd);
    logic [3:0] o;
    o = outs(s);
    chk($sformatf("%s.txOut", name),   o[3], tx);
    chk($sformatf("%s.busy", name),    o[2], bz);
    chk($sformatf("%s.done", name),    o[1], dn);
    chk($sformatf("%s.txReady", name), o[0], rd);
  endtask

  logic [8:0]  q_words[$];
  logic [15:0] q_bits[$];

  // Sends all queued words with txValid held high (chained frames), checking
  // every cycle against the queued expected frames. Starts and ends idle.
  task automatic run_stream(input int s, input string name);
    int         n;
    int         len;
    logic       last;
    logic [3:0] o;
    logic [15:0] bits;
    n   = q_words.size();
    len = frame_len(s) * CPB;
    @(negedge clk);
    set_in(s, 1'b1, q_words[0]);
    o = outs(s);
    chk($sformatf("%s.ready_c0", name), o[0], 1'b1);
    for (int f = 0; f < n; f++) begin
      bits = q_bits[f];
      for (int c = 1; c <= len; c++) begin
        @(negedge clk);
        if (c == 1) begin
          if (f + 1 < n) set_in(s, 1'b1, q_words[f+1]);
          else           set_in(s, 1'b0, 9'h0);
        end
        last = (c == len);
        check_cycle($sformatf("%s.f%0d.c%0d", name, f, c), s, bits[(c-1)/CPB], 1'b1, last, last);
      end
    end
    @(negedge clk);
    check_cycle($sformatf("%s.idle", name), s, 1'b1, 1'b0, 1'b0, 1'b1);
    q_words.delete();
    q_bits.delete();
  endtask

  typedef struct {
    int          sel;
    logic [8:0]  din;
    logic [15:0] exp_np;  // expected frame without parity
    logic [15:0] exp_p;   // expected frame with parity
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [3:0]  o;
    logic [15:0] fb;
    int          s;
    int          n;
    logic [8:0]  w;

    tbl[0] = '{0, 9'h0A5, 16'h034A, 16'h054A};
    tbl[1] = '{0, 9'h000, 16'h0200, 16'h0400};
    tbl[2] = '{0, 9'h0FF, 16'h03FE, 16'h05FE};
    tbl[3] = '{0, 9'h001, 16'h0202, 16'h0602};
    tbl[4] = '{1, 9'h01F, 16'h00FE, 16'h01BE};
    tbl[5] = '{1, 9'h00A, 16'h00D4, 16'h01D4};

    rst = 1'b1;
    en_a = 1'b1; valid_a = 1'b0; in_a = '0;
    en_b = 1'b1; valid_b = 1'b0; in_b = '0;
    #1;
    check_cycle("reset_a", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_cycle("reset_b", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_cycle("post_reset_a", 0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_cycle("post_reset_b", 1, 1'b1, 1'b0, 1'b0, 1'b1);

    // Table-driven single frames (T1 A5, T3 5-bit 2-stop, parity variants).
    for (int i = 0; i < 6; i++) begin
      q_words.push_back(tbl[i].din);
      q_bits.push_back(PAR_ON ? tbl[i].exp_p : tbl[i].exp_np);
      run_stream(tbl[i].sel, $sformatf("tbl%0d", i));
    end

    // T2: back-to-back 00 then FF with txValid held high.
    q_words.push_back(tbl[1].din);
    q_bits.push_back(PAR_ON ? tbl[1].exp_p : tbl[1].exp_np);
    q_words.push_back(tbl[2].din);
    q_bits.push_back(PAR_ON ? tbl[2].exp_p : tbl[2].exp_np);
    run_stream(0, "chain");

    // Randomized chained bursts against the frame model.
    for (int r = 0; r < 8; r++) begin
      s = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 3));
      for (int k = 0; k < n; k++) begin
        w = 9'($urandom) & ((s != 0) ? 9'h01F : 9'h0FF);
        q_words.push_back(w);
        q_bits.push_back(model_frame(s, w));
      end
      run_stream(s, $sformatf("rnd%0d", r));
    end

    // T5: en dropped at cycle 15 mid-DATA.
    fb = model_frame(0, 9'h0A5);
    @(negedge clk);
    set_in(0, 1'b1, 9'h0A5);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 1) set_in(0, 1'b0, 9'h0);
      check_cycle($sformatf("endrop.c%0d", c), 0, fb[(c-1)/CPB], 1'b1, 1'b0, 1'b0);
    end
    set_en(0, 1'b0);
    for (int c = 16; c <= 50; c++) begin
      @(negedge clk);
      check_cycle($sformatf("endrop.off%0d", c), 0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    // en low together with a valid word: not accepted.
    set_in(0, 1'b1, 9'h055);
    o = outs(0);
    chk("en_vs_valid.ready", o[0], 1'b0);
    @(negedge clk);
    check_cycle("en_vs_valid.next", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_in(0, 1'b0, 9'h0);
    set_en(0, 1'b1);
    q_words.push_back(9'h0A5);
    q_bits.push_back(fb);
    run_stream(0, "after_en");

    // T6: asynchronous reset in the middle of START.
    @(negedge clk);
    set_in(0, 1'b1, 9'h03C);
    @(negedge clk);
    set_in(0, 1'b0, 9'h0);
    check_cycle("pre_rst.start", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_cycle("async_rst", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_cycle("rst_release", 0, 1'b1, 1'b0, 1'b0, 1'b1);
    q_words.push_back(9'h03C);
    q_bits.push_back(model_frame(0, 9'h03C));
    run_stream(0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
